// File: rtl/yari_mem_arb.sv
// yari_mem_arb: merges the yari core's instruction (I) and data (D) ports onto
// one memory port with round-robin arbitration. Read responses are steered back
// to the issuing master through an in-order tag FIFO; writes are posted.
//
// Ports
//   clock, rst                       clock, asynchronous active-low reset
//   i_read/i_addr                    I master read request (held until accepted)
//   i_wait/i_rd_valid/i_rd_data      I handshake stall and read response
//   d_read/d_write/d_addr/d_wr_*     D master request (read and write exclusive)
//   d_wait/d_rd_valid/d_rd_data      D handshake stall and read response
//   m_read/m_write/m_addr/m_wr_*     memory request
//   m_wait                           memory stall of the presented request
//   m_rd_valid/m_rd_data             memory read response, in request order
//   err_orphan                       sticky: response arrived with no tag pending
module yari_mem_arb #(
   parameter int unsigned A_W     = 32,
   parameter int unsigned D_W     = 32,
   parameter int unsigned TAG_LG2 = 2
) (
   input  logic               clock,
   input  logic               rst,
   // I master
   input  logic               i_read,
   input  logic [A_W-1:0]     i_addr,
   output logic               i_wait,
   output logic               i_rd_valid,
   output logic [D_W-1:0]     i_rd_data,
   // D master
   input  logic               d_read,
   input  logic               d_write,
   input  logic [A_W-1:0]     d_addr,
   input  logic [D_W-1:0]     d_wr_data,
   input  logic [D_W/8-1:0]   d_wr_mask,
   output logic               d_wait,
   output logic               d_rd_valid,
   output logic [D_W-1:0]     d_rd_data,
   // memory
   output logic               m_read,
   output logic               m_write,
   output logic [A_W-1:0]     m_addr,
   output logic [D_W-1:0]     m_wr_data,
   output logic [D_W/8-1:0]   m_wr_mask,
   input  logic               m_wait,
   input  logic               m_rd_valid,
   input  logic [D_W-1:0]     m_rd_data,
   // status
   output logic               err_orphan
);

   localparam int unsigned DEPTH = 1 << TAG_LG2;
   localparam int unsigned CNT_W = TAG_LG2 + 1;
   localparam int unsigned M_W   = D_W / 8;

   typedef enum logic {
      MST_I = 1'b0,
      MST_D = 1'b1
   } mst_e;

   // tag FIFO state: one bit per entry holds the issuing master
   logic [DEPTH-1:0]   tag_q,      tag_d;
   logic [TAG_LG2-1:0] wr_ptr_q,   wr_ptr_d;
   logic [TAG_LG2-1:0] rd_ptr_q,   rd_ptr_d;
   logic [CNT_W-1:0]   count_q,    count_d;
   mst_e               last_grant_q, last_grant_d;
   logic               err_orphan_q, err_orphan_d;

   logic fifo_full;
   logic fifo_empty;
   logic i_elig;
   logic d_elig;
   logic grant_i;
   logic grant_d;
   logic accept;
   logic push;
   logic pop;
   logic head_tag;

   // Eligibility and round-robin grant; fullness uses the registered count so
   // m_rd_valid never reaches the request side combinationally.
   always_comb begin
      fifo_full  = (count_q == CNT_W'(DEPTH));
      fifo_empty = (count_q == '0);
      i_elig     = rst & i_read & ~fifo_full;
      d_elig     = rst & (d_write | (d_read & ~fifo_full));
      grant_i    = i_elig & (~d_elig | (last_grant_q == MST_D));
      grant_d    = d_elig & (~i_elig | (last_grant_q == MST_I));
      accept     = (grant_i | grant_d) & ~m_wait;
      push       = accept & (grant_i | (grant_d & ~d_write));
      pop        = rst & m_rd_valid & ~fifo_empty;
      head_tag   = tag_q[rd_ptr_q];
   end

   // Memory request mux and master handshakes
   always_comb begin
      m_read    = grant_i | (grant_d & ~d_write);
      m_write   = grant_d & d_write;
      m_addr    = grant_d ? d_addr : i_addr;
      m_wr_data = d_wr_data;
      m_wr_mask = grant_d ? d_wr_mask : M_W'(0);
      i_wait    = ~(grant_i & ~m_wait);
      d_wait    = ~(grant_d & ~m_wait);
   end

   // Response steering by head tag; data fans out to both masters
   always_comb begin
      i_rd_valid = pop & (head_tag == MST_D ? 1'b0 : 1'b1);
      d_rd_valid = pop & (head_tag == MST_D ? 1'b1 : 1'b0);
      i_rd_data  = m_rd_data;
      d_rd_data  = m_rd_data;
      err_orphan = err_orphan_q;
   end

   // Next-state for tag FIFO, round-robin pointer and orphan flag
   always_comb begin
      tag_d        = tag_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      last_grant_d = last_grant_q;
      err_orphan_d = err_orphan_q;

      if (accept) begin
         last_grant_d = grant_d ? MST_D : MST_I;
      end

      if (push) begin
         tag_d[wr_ptr_q] = grant_d;
         wr_ptr_d        = wr_ptr_q + TAG_LG2'(1);
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + TAG_LG2'(1);
      end

      unique case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      // a response with nothing outstanding is dropped and flagged
      if (m_rd_valid & fifo_empty) begin
         err_orphan_d = 1'b1;
      end
   end

   // State registers
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         tag_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= MST_I;
         err_orphan_q <= 1'b0;
      end else begin
         tag_q        <= tag_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
         err_orphan_q <= err_orphan_d;
      end
   end

endmodule
